// File: rtl/jlsemi_util_clkmux_switch_ctrl.sv
// Clock-mux select sequencer: on an accepted switch request it closes the
// downstream clock gate, lets the old clock drain, flips the mux select,
// lets the new clock settle, then reopens the gate. DFT test-clock mode
// forces the clk1 path with the gate open and aborts any sequence.
`timescale 1ns/1ps
module jlsemi_util_clkmux_switch_ctrl #(
  parameter int unsigned GATE_WAIT   = 4,
  parameter int unsigned SETTLE_WAIT = 8,
  parameter int unsigned CNT_W       = 8,
  parameter bit          RST_SEL     = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_vld_i,
  input  logic       req_sel_i,
  output logic       req_rdy_o,
  input  logic       dft_test_clk_en,
  output logic       sel_o,
  output logic       gate_en_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] sw_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE          = 2'd0,
    S_GATE_OFF      = 2'd1,
    S_SWITCH_SETTLE = 2'd2,
    S_GATE_ON       = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] GATE_LOAD   = GATE_WAIT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] SETTLE_LOAD = SETTLE_WAIT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             tgt_q, tgt_d;
  logic             gate_q, gate_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       sw_cnt_q, sw_cnt_d;
  logic             accept_s;
  logic             cnt_last_s;

  // Ready only out of reset, in IDLE, and with no DFT override pending.
  assign req_rdy_o  = rst_n_i & (state_q == S_IDLE) & ~dft_test_clk_en;
  assign accept_s   = req_vld_i & req_rdy_o;
  assign cnt_last_s = (cnt_q == CNT_ONE);

  assign sel_o     = sel_q;
  assign gate_en_o = gate_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign sw_cnt_o  = sw_cnt_q;

  // Next-state and next-output logic; DFT override beats acceptance and expiry.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    tgt_d    = tgt_q;
    gate_d   = gate_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sw_cnt_d = sw_cnt_q;
    if (dft_test_clk_en) begin
      state_d = S_IDLE;
      cnt_d   = CNT_ZERO;
      sel_d   = 1'b1;
      gate_d  = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            if (req_sel_i == sel_q) begin
              // Already on the requested source: acknowledge without gating.
              done_d = 1'b1;
            end else begin
              state_d = S_GATE_OFF;
              cnt_d   = GATE_LOAD;
              tgt_d   = req_sel_i;
              gate_d  = 1'b0;
              busy_d  = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_GATE_OFF: begin
          if (cnt_last_s) begin
            // Old clock has drained with the gate closed: safe to flip.
            state_d = S_SWITCH_SETTLE;
            sel_d   = tgt_q;
            cnt_d   = SETTLE_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_SWITCH_SETTLE: begin
          if (cnt_last_s) begin
            state_d  = S_GATE_ON;
            cnt_d    = CNT_ZERO;
            gate_d   = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            sw_cnt_d = sw_cnt_q + 8'd1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_GATE_ON: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
          gate_d  = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State, counter and registered outputs with asynchronous clear/preset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      sel_q    <= RST_SEL;
      tgt_q    <= RST_SEL;
      gate_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sw_cnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      tgt_q    <= tgt_d;
      gate_q   <= gate_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sw_cnt_q <= sw_cnt_d;
    end
  end

endmodule

// File: tb/tb_jlsemi_util_clkmux_switch_ctrl.sv
// Self-checking bench for the clock-mux switch sequencer: table of single
// cycle vectors, timed switch sequences, DFT abort, counter wrap, async reset.
`timescale 1ns/1ps
module tb_jlsemi_util_clkmux_switch_ctrl;

  localparam int GW = 4;
  localparam int SW = 8;

  typedef struct packed {
    logic       sel;
    logic       gate;
    logic       busy;
    logic       done;
    logic       rdy;
    logic [7:0] cnt;
  } exp_t;

  typedef struct packed {
    logic vld;
    logic rsel;
    logic dft;
    exp_t e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_vld, req_sel, dft;
  logic       req_rdy, sel, gate_en, busy, done;
  logic [7:0] sw_cnt;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  logic [7:0] exp_cnt = 8'd0;
  bit   have_prev = 1'b0;
  logic prev_sel, prev_gate, prev_dft;
  vec_t tbl[11];

  jlsemi_util_clkmux_switch_ctrl #(
    .GATE_WAIT(GW), .SETTLE_WAIT(SW), .CNT_W(8), .RST_SEL(1'b0)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_vld_i(req_vld), .req_sel_i(req_sel),
    .req_rdy_o(req_rdy), .dft_test_clk_en(dft), .sel_o(sel), .gate_en_o(gate_en),
    .busy_o(busy), .done_o(done), .sw_cnt_o(sw_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the edge, push the expected outputs,
  // then pop and compare at the falling edge.
  task automatic cyc(input logic v, input logic s, input logic d, input exp_t e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    req_vld = v;
    req_sel = s;
    dft     = d;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s.scoreboard: got empty queue expected one entry", nm);
    end else begin
      x = sb_q.pop_front();
      chk1({nm, ".sel"},  sel,     x.sel);
      chk1({nm, ".gate"}, gate_en, x.gate);
      chk1({nm, ".busy"}, busy,    x.busy);
      chk1({nm, ".done"}, done,    x.done);
      chk1({nm, ".rdy"},  req_rdy, x.rdy);
      chk8({nm, ".cnt"},  sw_cnt,  x.cnt);
    end
    // Select must hold whenever the gate is open, except right after DFT.
    if (have_prev && !prev_dft && (prev_gate || gate_en))
      chk1({nm, ".sel_stable_gate_open"}, sel, prev_sel);
    prev_sel  = sel;
    prev_gate = gate_en;
    prev_dft  = d;
    have_prev = 1'b1;
  endtask

  // Full switch to tgt accepted at d=0; noise toggles req inputs while busy;
  // abort_at>0 asserts DFT in that cycle and checks the forced state after.
  task automatic run_switch(input logic tgt, input bit noise, input int abort_at, input string nm);
    int   last;
    logic v, s, d;
    exp_t e;
    last = (abort_at > 0) ? abort_at + 1 : GW + SW + 2;
    for (int k = 0; k <= last; k++) begin
      v = 1'b0; s = 1'b0; d = 1'b0;
      if (k == 0) begin
        v = 1'b1; s = tgt;
      end else if (abort_at > 0 && k == abort_at) begin
        d = 1'b1;
      end else if (noise && k <= GW + SW + 1) begin
        v = 1'b1; s = k[0];
      end
      e = '{sel: ~tgt, gate: 1'b1, busy: 1'b0, done: 1'b0, rdy: 1'b1, cnt: exp_cnt};
      if (abort_at > 0 && k == abort_at + 1) begin
        e.sel = 1'b1;
      end else if (k >= 1 && k <= GW) begin
        e.gate = 1'b0; e.busy = 1'b1; e.rdy = 1'b0;
      end else if (k > GW && k <= GW + SW) begin
        e.sel = tgt; e.gate = 1'b0; e.busy = 1'b1; e.rdy = 1'b0;
      end else if (k == GW + SW + 1) begin
        exp_cnt = exp_cnt + 8'd1;
        e.sel = tgt; e.done = 1'b1; e.rdy = 1'b0; e.cnt = exp_cnt;
      end else if (k == GW + SW + 2) begin
        e.sel = tgt;
      end
      cyc(v, s, d, e, $sformatf("%s[%0d]", nm, k));
    end
  endtask

  initial begin
    //           vld   rsel  dft    sel   gate  busy  done  rdy   cnt
    tbl[0]  = '{1'b0, 1'b0, 1'b0, '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0}};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0}};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0}};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0}};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0}};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0}};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0}};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}};
    tbl[10] = '{1'b0, 1'b0, 1'b0, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0}};

    rst_n = 1'b0; req_vld = 1'b0; req_sel = 1'b0; dft = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("reset.rdy",  req_rdy, 1'b0);
    chk1("reset.sel",  sel,     1'b0);
    chk1("reset.gate", gate_en, 1'b1);
    chk1("reset.busy", busy,    1'b0);
    chk1("reset.done", done,    1'b0);
    chk8("reset.cnt",  sw_cnt,  8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single-cycle vectors: reset idle, same-source requests, DFT in idle.
    for (int i = 0; i < 11; i++)
      cyc(tbl[i].vld, tbl[i].rsel, tbl[i].dft, tbl[i].e, $sformatf("tbl%0d", i));

    // 1->0 switch aborted by DFT in cycle 7, then a normal 1->0 switch.
    run_switch(1'b0, 1'b0, 7, "dft_abort");
    run_switch(1'b0, 1'b0, 0, "sw_1to0");
    // 0->1 switch with request inputs toggling while busy.
    run_switch(1'b1, 1'b1, 0, "sw_0to1_noise");

    // Alternating switches until the counter has wrapped after 256 switches.
    for (int i = 0; i < 254; i++)
      run_switch((i % 2 == 1) ? 1'b1 : 1'b0, 1'b0, 0, $sformatf("wrap%0d", i));
    chk8("wrap.final_cnt", sw_cnt, 8'd0);

    run_switch(1'b0, 1'b0, 0, "pre_rst_a");
    run_switch(1'b1, 1'b0, 0, "pre_rst_b");

    // Async reset two cycles into GATE_OFF of a 1->0 switch.
    cyc(1'b1, 1'b0, 1'b0, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, exp_cnt}, "mid_rst0");
    cyc(1'b0, 1'b0, 1'b0, '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, exp_cnt}, "mid_rst1");
    cyc(1'b0, 1'b0, 1'b0, '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, exp_cnt}, "mid_rst2");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst.sel",  sel,     1'b0);
    chk1("async_rst.gate", gate_en, 1'b1);
    chk1("async_rst.busy", busy,    1'b0);
    chk1("async_rst.done", done,    1'b0);
    chk1("async_rst.rdy",  req_rdy, 1'b0);
    chk8("async_rst.cnt",  sw_cnt,  8'd0);
    have_prev = 1'b0;
    exp_cnt   = 8'd0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0}, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jlsemi_util_clkmux_switch_ctrl.md
Name: jlsemi_util_clkmux_switch_ctrl

Overview:
Sequencer for a two-input clock mux select line. On a handshaked switch request it gates the downstream clock off, waits for the old clock to drain, flips the mux select, waits for the new clock to settle, then re-enables the gate. It runs on one always-on reference clock, sits beside the clock mux cell, and drives that cell's select and the downstream clock-gate enable. DFT test-clock mode overrides the sequence.

Parameters:
GATE_WAIT, 4, cycles between gate-off and select flip; legal range 1..2^CNT_W-1
SETTLE_WAIT, 8, cycles between select flip and gate-on; legal range 1..2^CNT_W-1
CNT_W, 8, width of internal wait counter
RST_SEL, 0, select value after reset (0 = clk0, 1 = clk1)

Ports:
clk_i  input  1  always-on reference clock
rst_n_i  input  1  asynchronous active-low reset
req_vld_i  input  1  switch request valid
req_sel_i  input  1  requested source (0 = clk0, 1 = clk1)
req_rdy_o  output  1  controller ready to accept a request
dft_test_clk_en  input  1  DFT override, high = force clk1 path and gate open
sel_o  output  1  to clock mux select, registered
gate_en_o  output  1  downstream clock-gate enable, registered
busy_o  output  1  switch sequence in progress
done_o  output  1  one-cycle pulse when a request completes
sw_cnt_o  output  8  number of completed real switches, wraps 255 -> 0

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_n_i. All state is in flops on clk_i with async clear/preset.
- Reset values: sel_o = RST_SEL, gate_en_o = 1, busy_o = 0, done_o = 0, sw_cnt_o = 0, req_rdy_o = 0 during reset and 1 in the first cycle after release, FSM = IDLE, counter = 0.
- FSM states: IDLE, GATE_OFF, SWITCH_SETTLE, GATE_ON.
- Acceptance: a request is accepted in cycle T when req_vld_i = 1, req_rdy_o = 1 and dft_test_clk_en = 0.
- req_rdy_o = (state == IDLE) && !dft_test_clk_en. It is combinational from state and the DFT pin.
- Same-source request: req_sel_i == sel_o at acceptance.
  - FSM stays in IDLE; no gating.
  - done_o = 1 at T+1; sw_cnt_o unchanged.
- Real switch, accepted at T:
  - Move to GATE_OFF. gate_en_o = 0 and busy_o = 1 from T+1.
  - Counter loads GATE_WAIT and decrements each cycle.
  - At T+GATE_WAIT+1, sel_o toggles to the latched req_sel_i and the FSM moves to SWITCH_SETTLE; counter loads SETTLE_WAIT.
  - At T+GATE_WAIT+SETTLE_WAIT+1 (GATE_ON, one cycle): gate_en_o = 1, done_o = 1, sw_cnt_o increments, busy_o = 0.
  - FSM returns to IDLE, so req_rdy_o = 1 again at T+GATE_WAIT+SETTLE_WAIT+2.
- Invariant: sel_o never changes in a cycle where gate_en_o = 1 (DFT override excepted).
- Request input changes while busy are ignored. The target select is latched at acceptance.
- DFT override: dft_test_clk_en = 1 in any state.
  - Next cycle: FSM = IDLE, counter cleared, sel_o = 1, gate_en_o = 1, busy_o = 0.
  - No done_o pulse and no sw_cnt_o change; an in-flight request is aborted.
  - When dft_test_clk_en falls, sel_o stays 1. A later request to 0 performs a full switch sequence.
- Simultaneous events: DFT override has priority over acceptance and counter expiry.
- Reset mid-sequence: all outputs return to their reset values asynchronously.
- sw_cnt_o: wraps modulo 256 and counts only real switches.

Test Plan:
- Reset release, RST_SEL=0 -> sel_o=0, gate_en_o=1, req_rdy_o=1, sw_cnt_o=0, done_o=0.
- Defaults (GATE_WAIT=4, SETTLE_WAIT=8); request sel=1 accepted at cycle 0 -> gate_en_o=0 on cycles 1..12, sel_o=1 from cycle 5, gate_en_o=1 and done_o=1 at cycle 13, sw_cnt_o=1, req_rdy_o=1 at cycle 14.
- Request sel=0 while sel_o=0 -> done_o pulse next cycle, gate_en_o stays 1, sw_cnt_o unchanged, no busy.
- req_sel_i toggled and req_vld_i held during a sequence -> req_rdy_o=0 throughout, final sel_o equals the value latched at acceptance, exactly one done_o.
- dft_test_clk_en asserted at cycle 7 of a 1->0 switch -> next cycle sel_o=1, gate_en_o=1, busy_o=0, no done_o, sw_cnt_o unchanged. After deassert, a request for 0 completes normally.
- 256 alternating real switches -> sw_cnt_o wraps to 0. Checker confirms sel_o never toggles while gate_en_o=1 outside DFT. Async reset pulsed mid-GATE_OFF returns all outputs to reset values immediately.
